seq_mult_ctrl: RTL

Sequencing controller for the bit-serial signed multiplier datapath (`seq_mult`). It accepts one multiply request at a time through a valid/ready handshake. It walks the product-scanning schedule, one digit pair per cycle, column by column, and drives every control input of the datapath. It also flags each P-bit product digit as it appears on the datapath output. It sits between the operand source and one `seq_mult` instance; operands a/b go straight to the datapath.

---
 rtl/seq_mult_ctrl.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/seq_mult_ctrl.sv
// Product-scanning sequencer for the bit-serial signed multiplier datapath (seq_mult).
// Optional performance counters are enabled by defining SEQ_MULT_CTRL_PERF_EN.
module seq_mult_ctrl #(
  parameter int P         = 2,
  parameter int MAX_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [$clog2(MAX_WIDTH/P)+1:0]  in_digits,
  output logic [$clog2(MAX_WIDTH/P)+1:0]  bitSize,
  output logic                            start,
  output logic                            countDown,
  output logic                            countLast2,
  output logic                            lastOut,
  output logic                            busy,
  output logic [2:0]                      muxSelA,
  output logic [2:0]                      muxSelB,
  output logic                            invertFirstBit,
  output logic                            invertSecondRow,
  output logic                            placeOne,
  output logic                            out_valid,
  output logic                            out_last,
`ifdef SEQ_MULT_CTRL_PERF_EN
  output logic [31:0]                     perf_ops,
  output logic [31:0]                     perf_busy,
`endif
  output logic                            done
);

  localparam int DMAX = MAX_WIDTH / P;
  localparam int NW   = $clog2(DMAX) + 2;
  localparam int KW   = $clog2(2 * DMAX);
  localparam int CW   = NW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, LAST = 2'd2} state_t;

  typedef struct packed {
    logic       count_down;
    logic       count_last2;
    logic       last_out;
    logic       busy;
    logic       in_ready;
    logic [2:0] sel_a;
    logic [2:0] sel_b;
    logic       inv_first;
    logic       inv_second;
    logic       place_one;
  } ctrl_t;

  // Control word for a given schedule position; registered so every output comes from a flop.
  function automatic ctrl_t decode(input state_t st, input logic [KW-1:0] k,
                                   input logic [2:0] i, input logic [NW-1:0] n);
    ctrl_t          c;
    logic [CW-1:0]  k_e, i_e, n_e, nm1, last_i, j_e;
    k_e    = CW'(k);
    i_e    = CW'(i);
    n_e    = CW'(n);
    nm1    = n_e - CW'(1);
    last_i = (k_e < nm1) ? k_e : nm1;
    j_e    = k_e - i_e;
    c          = '0;
    c.in_ready = (st == IDLE);
    case (st)
      MAC: begin
        c.busy        = 1'b1;
        c.sel_a       = i;
        c.sel_b       = j_e[2:0];
        c.count_last2 = (i_e == last_i);
        c.count_down  = (k_e >= nm1);
        c.inv_first   = (i_e == nm1) && (j_e != nm1);
        c.inv_second  = (j_e == nm1) && (i_e != nm1);
        c.place_one   = c.count_last2 && (k_e == n_e) && (n_e >= CW'(2));
      end
      LAST: begin
        c.busy     = 1'b1;
        c.last_out = 1'b1;
      end
      default: c.in_ready = (st == IDLE);
    endcase
    return c;
  endfunction

  state_t         state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [2:0]     i_q, i_d;
  logic [NW-1:0]  n_q, n_d;
  ctrl_t          ctrl_q, ctrl_d;
  logic           out_valid_q, out_valid_d;
  logic           out_last_q, out_last_d;
  logic           done_q, done_d;
  logic [CW-1:0]  k_e_s, n_e_s;
  logic [2:0]     first_s;

  // Next-state: walk column k from its first to its last index, then advance the column.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    i_d     = i_q;
    n_d     = n_q;
    k_e_s   = CW'(k_q);
    n_e_s   = CW'(n_q);
    // first index of column k+1 is max(0, k+2-N)
    first_s = ((k_e_s + CW'(2)) > n_e_s) ? 3'(k_e_s + CW'(2) - n_e_s) : 3'd0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_digits == NW'(0)) begin
            n_d = NW'(1);
          end else if (in_digits > NW'(DMAX)) begin
            n_d = NW'(DMAX);
          end else begin
            n_d = in_digits;
          end
          k_d     = '0;
          i_d     = 3'd0;
          state_d = MAC;
        end else begin
          state_d = IDLE;
        end
      end
      MAC: begin
        if (ctrl_q.count_last2) begin
          if (k_e_s == ((n_e_s << 1) - CW'(2))) begin
            state_d = LAST;
            k_d     = '0;
            i_d     = 3'd0;
          end else begin
            k_d = k_q + KW'(1);
            i_d = first_s;
          end
        end else begin
          i_d = i_q + 3'd1;
        end
      end
      LAST:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ctrl_d      = decode(state_d, k_d, i_d, n_d);
    out_valid_d = ctrl_q.count_last2 | ctrl_q.last_out;
    out_last_d  = ctrl_q.last_out;
    done_d      = (state_q == LAST);
  end

  // FSM state, schedule counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      i_q         <= 3'd0;
      n_q         <= '0;
      ctrl_q      <= decode(IDLE, '0, 3'd0, '0);
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      i_q         <= i_d;
      n_q         <= n_d;
      ctrl_q      <= ctrl_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  // start must be combinational so the datapath captures a/b in the handshake cycle
  assign start           = (state_q == IDLE) && in_valid;
  assign in_ready        = ctrl_q.in_ready;
  assign bitSize         = n_q;
  assign countDown       = ctrl_q.count_down;
  assign countLast2      = ctrl_q.count_last2;
  assign lastOut         = ctrl_q.last_out;
  assign busy            = ctrl_q.busy;
  assign muxSelA         = ctrl_q.sel_a;
  assign muxSelB         = ctrl_q.sel_b;
  assign invertFirstBit  = ctrl_q.inv_first;
  assign invertSecondRow = ctrl_q.inv_second;
  assign placeOne        = ctrl_q.place_one;
  assign out_valid       = out_valid_q;
  assign out_last        = out_last_q;
  assign done            = done_q;

`ifdef SEQ_MULT_CTRL_PERF_EN
  logic [31:0] perf_ops_q, perf_ops_d;
  logic [31:0] perf_busy_q, perf_busy_d;

  // Saturating activity counters.
  always_comb begin
    if (done_q && (perf_ops_q != 32'hFFFF_FFFF)) begin
      perf_ops_d = perf_ops_q + 32'd1;
    end else begin
      perf_ops_d = perf_ops_q;
    end
    if (ctrl_q.busy && (perf_busy_q != 32'hFFFF_FFFF)) begin
      perf_busy_d = perf_busy_q + 32'd1;
    end else begin
      perf_busy_d = perf_busy_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ops_q  <= 32'd0;
      perf_busy_q <= 32'd0;
    end else begin
      perf_ops_q  <= perf_ops_d;
      perf_busy_q <= perf_busy_d;
    end
  end

  assign perf_ops  = perf_ops_q;
  assign perf_busy = perf_busy_q;
`endif

endmodule
